// File: rtl/demux_channel_sequencer.sv
// Steps a 1-to-8 demux select through the set bits of a latched channel mask,
// holding each channel for a programmable dwell. Single-pass or wrap-around.
module demux_channel_sequencer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic [2:0]         sel_out,
  output logic               sel_valid,
  output logic               chan_strobe,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  // Handshake: start is a level request, taken in any edge where the FSM is
  // not in RUN and abort is low; abort acts only in RUN; no backpressure.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t               state_q, state_d;
  logic [7:0]           mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 cont_q, cont_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [7:0]           above_mask;
  logic                 has_above;
  logic                 cnt_zero;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // The counter holds cycles remaining after the current one, so N-1 at entry.
  function automatic logic [DWELL_W-1:0] first_cnt(input logic [DWELL_W-1:0] d);
    first_cnt = (d == '0) ? '0 : d - CNT_ONE;
  endfunction

  assign accept     = (state_q != S_RUN) && start && !abort;
  assign above_mask = mask_q & (8'hFE << sel_q);
  assign has_above  = |above_mask;
  assign cnt_zero   = (cnt_q == '0);

  // State register plus all output/datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cont_q   <= cont_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (chan_mask == 8'h00) ? S_DONE : S_RUN;
        else        state_d = S_IDLE;
      end
      S_RUN: begin
        if (abort)                               state_d = S_IDLE;
        else if (cnt_zero && !has_above && !cont_q) state_d = S_DONE;
        else                                     state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computes the values the output flops take next cycle.
  always_comb begin
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    cont_d   = cont_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    strobe_d = 1'b0;
    valid_d  = (state_d == S_RUN);
    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          mask_d  = chan_mask;
          dwell_d = dwell;
          cont_d  = continuous;
          if (chan_mask != 8'h00) begin
            sel_d    = lowest_bit(chan_mask);
            cnt_d    = first_cnt(dwell);
            strobe_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!abort) begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (has_above) begin
            sel_d    = lowest_bit(above_mask);
            cnt_d    = first_cnt(dwell_q);
            strobe_d = 1'b1;
          end else if (cont_q) begin
            sel_d    = lowest_bit(mask_q);
            cnt_d    = first_cnt(dwell_q);
            strobe_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign sel_out     = sel_q;
  assign sel_valid   = valid_q;
  assign chan_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_demux_channel_sequencer.sv
// Directed and randomized checks of demux_channel_sequencer against a
// trace model built from the channel-visit rules.
module tb_demux_channel_sequencer;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic         abort;
  logic [7:0]   chan_mask;
  logic [W-1:0] dwell;
  logic         continuous;
  logic [2:0]   sel_out;
  logic         sel_valid;
  logic         chan_strobe;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  demux_channel_sequencer #(.DWELL_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .chan_mask   (chan_mask),
    .dwell       (dwell),
    .continuous  (continuous),
    .sel_out     (sel_out),
    .sel_valid   (sel_valid),
    .chan_strobe (chan_strobe),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {sel_out, sel_valid, chan_strobe, busy, done}
  logic [6:0] got;
  assign got = {sel_out, sel_valid, chan_strobe, busy, done};

  logic [6:0] exp_q[$];
  logic [2:0] last_sel;
  int checks;
  int failures;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs from the cycle after start onwards.
  // stop_at>0: abort (or reset) applied while showing entry stop_at.
  task automatic build_model(input logic [7:0] m, input logic [W-1:0] d,
                             input bit c, input int stop_at,
                             input bit by_reset, input bit chain);
    int chans[$];
    logic [6:0] full[$];
    int n;
    logic [6:0] e;
    n = (d == 0) ? 1 : int'(d);
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    if (chans.size() == 0) begin
      exp_q.push_back({last_sel, 4'b0001});
      if (!chain) exp_q.push_back({last_sel, 4'b0000});
      return;
    end
    foreach (chans[j])
      for (int k = 0; k < n; k++)
        full.push_back({3'(chans[j]), 1'b1, (k == 0), 1'b1, 1'b0});
    if (stop_at == 0) begin
      foreach (full[j]) exp_q.push_back(full[j]);
      last_sel = 3'(chans[chans.size()-1]);
      exp_q.push_back({last_sel, 4'b0001});
      if (!chain) exp_q.push_back({last_sel, 4'b0000});
    end else begin
      for (int i = 0; i < stop_at; i++) begin
        e = full[i % full.size()];
        exp_q.push_back(e);
        last_sel = e[6:4];
      end
      if (by_reset) last_sel = 3'd0;
      exp_q.push_back({last_sel, 4'b0000});
    end
  endtask

  task automatic run_seq(input logic [7:0] m, input logic [W-1:0] d, input bit c,
                         input int stop_at, input bit by_reset, input bit chain,
                         input string tag);
    logic [6:0] e;
    int i;
    build_model(m, d, c, stop_at, by_reset, chain);
    chan_mask  = m;
    dwell      = d;
    continuous = c;
    start      = 1'b1;
    abort      = 1'b0;
    step();
    i = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, e);
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      if (i == stop_at) begin
        if (by_reset) reset = 1'b1;
        else          abort = 1'b1;
      end else if (e[1]) begin
        start = 1'($urandom_range(0, 1));
      end
      chan_mask  = 8'($urandom);
      dwell      = W'($urandom);
      continuous = 1'($urandom);
      if (exp_q.size() > 0) step();
      i++;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    logic [W-1:0] d;
    bit c;
    int stop_at;
    bit by_reset;
    bit chain;
    int cyc;

    checks = 0;
    failures = 0;
    last_sel = 3'd0;
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    chan_mask = 8'hFF;
    dwell = W'(3);
    continuous = 1'b0;

    // Reset holds everything low even with start requested
    repeat (3) begin
      step();
      check("reset", 7'h00);
    end
    reset = 1'b0;

    // First start taken right after reset release
    run_seq(8'hA5, W'(2), 1'b0, 0, 1'b0, 1'b0, "mask_a5");
    run_seq(8'h00, W'(5), 1'b0, 0, 1'b0, 1'b0, "mask_zero");
    run_seq(8'h80, W'(0), 1'b0, 0, 1'b0, 1'b0, "dwell_zero");
    run_seq(8'h81, W'(1), 1'b1, 5, 1'b0, 1'b0, "cont_abort");
    run_seq(8'h0F, W'(3), 1'b0, 0, 1'b0, 1'b1, "chain_first");
    run_seq(8'hF0, W'(1), 1'b0, 0, 1'b0, 1'b0, "chain_second");

    // Reset mid-run, one quiet cycle, then restart
    run_seq(8'hA5, W'(2), 1'b0, 4, 1'b1, 1'b0, "reset_mid");
    step();
    check("reset_idle", {last_sel, 4'b0000});
    run_seq(8'hA5, W'(2), 1'b0, 0, 1'b0, 1'b0, "after_reset");

    // abort together with start is rejected
    chan_mask = 8'h3C;
    dwell = W'(1);
    start = 1'b1;
    abort = 1'b1;
    step();
    check("abort_start_a", {last_sel, 4'b0000});
    start = 1'b0;
    abort = 1'b0;
    step();
    check("abort_start_b", {last_sel, 4'b0000});

    // Full-scale dwell
    run_seq(8'h10, {W{1'b1}}, 1'b0, 0, 1'b0, 1'b0, "dwell_max");

    // Randomized runs
    for (int it = 0; it < 40; it++) begin
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      d = W'($urandom_range(0, 4));
      c = 1'($urandom_range(0, 1));
      stop_at = 0;
      by_reset = 1'b0;
      chain = 1'b0;
      cyc = $countones(m) * ((d == 0) ? 1 : int'(d));
      if (m != 8'h00 && c) begin
        stop_at = $urandom_range(1, 25);
      end else if (m != 8'h00 && $urandom_range(0, 2) == 0) begin
        stop_at = $urandom_range(1, cyc);
      end
      if (stop_at > 0) by_reset = ($urandom_range(0, 3) == 0);
      else             chain = 1'($urandom_range(0, 1));
      run_seq(m, d, c, stop_at, by_reset, chain, "random");
    end
    step();
    check("final_idle", {last_sel, 4'b0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
